// File: rtl/cpu_core_sc64.sv
// Single-cycle 64-bit MIPS-subset core: fetch, decode, execute, memory and
// writeback all resolve within one clock. Instruction ROM and data RAM have
// no load ports; their contents are placed there from outside the core.

module cpu_imem #(
  parameter int IMEM_DEPTH = 256,
  parameter int AW         = 8
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  logic [31:0] rom [IMEM_DEPTH];

  assign data = rom[addr];
endmodule

module cpu_dmem #(
  parameter int DMEM_DEPTH = 256,
  parameter int AW         = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [63:0] ram [DMEM_DEPTH];

  assign rdata = ram[addr];

  // Store port; contents are never cleared so preloaded data survives reset
  always @(posedge clk) begin
    if (we) ram[addr] <= wdata;
  end
endmodule

module cpu_core_sc64 #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic [63:0]        pc, pc_next, pc_plus4, br_target;
  logic [31:0]        instr;
  logic [5:0]         op, funct;
  logic [4:0]         rs, rt, rd, wb_addr;
  logic [15:0]        imm;
  logic signed [63:0] imm_sext, rs_val, rt_val, alu_res, mem_addr, mem_rdata, wb_data;
  logic               alu_ok, reg_we, mem_we;
  logic [63:0]        regs [32];
  logic               unused_bits;

  // Signed divide with the two non-trapping corner cases pinned down:
  // divide-by-zero gives 0, and MIN / -1 wraps back to MIN.
  function automatic logic signed [63:0] sdiv(input logic signed [63:0] a,
                                              input logic signed [63:0] b);
    logic signed [63:0] most_neg;
    most_neg = {1'b1, 63'd0};
    if (b == 64'sd0)
      return 64'sd0;
    else if ((a == most_neg) && (b == -64'sd1))
      return most_neg;
    else
      return a / b;
  endfunction

  cpu_imem #(.IMEM_DEPTH(IMEM_DEPTH), .AW(IAW)) u_imem (
    .addr (pc[IAW+1:2]),
    .data (instr)
  );

  cpu_dmem #(.DMEM_DEPTH(DMEM_DEPTH), .AW(DAW)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr[DAW+2:3]),
    .wdata (rt_val),
    .rdata (mem_rdata)
  );

  assign op        = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign funct     = instr[5:0];
  assign imm       = instr[15:0];
  assign imm_sext  = {{48{imm[15]}}, imm};

  // Register 0 is hard-wired to zero on both read ports
  assign rs_val    = (rs == 5'd0) ? 64'sd0 : regs[rs];
  assign rt_val    = (rt == 5'd0) ? 64'sd0 : regs[rt];

  assign mem_addr  = rs_val + imm_sext;
  assign pc_plus4  = pc + 64'd4;
  assign br_target = pc_plus4 + {imm_sext[61:0], 2'b00};

  // Shamt field and RAM address bits outside the word index are don't-care
  assign unused_bits = ^{instr[10:6], mem_addr[63:DAW+3], mem_addr[2:0]};

  // R-type ALU; alu_ok drops for unsupported funct codes so nothing is written
  always_comb begin
    alu_res = 64'sd0;
    alu_ok  = 1'b1;
    case (funct)
      FN_ADD:  alu_res = rs_val + rt_val;
      FN_SUB:  alu_res = rs_val - rt_val;
      FN_MULT: alu_res = rs_val * rt_val;
      FN_DIV:  alu_res = sdiv(rs_val, rt_val);
      FN_AND:  alu_res = rs_val & rt_val;
      FN_OR:   alu_res = rs_val | rt_val;
      FN_SLT:  alu_res = (rs_val < rt_val) ? 64'sd1 : 64'sd0;
      default: alu_ok  = 1'b0;
    endcase
  end

  // Main decode: writeback select, store enable and next PC
  always_comb begin
    reg_we  = 1'b0;
    wb_addr = rd;
    wb_data = alu_res;
    mem_we  = 1'b0;
    pc_next = pc_plus4;
    case (op)
      OP_LW: begin
        reg_we  = 1'b1;
        wb_addr = rt;
        wb_data = mem_rdata;
      end
      // A store coinciding with an asserted reset is dropped
      OP_SW:    mem_we = reset;
      OP_BEQ:   if (rs_val == rt_val) pc_next = br_target;
      OP_RTYPE: reg_we = alu_ok;
      default:  ;
    endcase
  end

  // PC and register file; reset clears both immediately, writes to $0 are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 64'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
    end else begin
      pc <= pc_next;
      if (reg_we && (wb_addr != 5'd0)) regs[wb_addr] <= wb_data;
    end
  end
endmodule

// File: tb/tb_cpu_core_sc64.sv
// Directed bench for cpu_core_sc64: programs are assembled into the ROM,
// data preloaded into the RAM, and results read back from RAM and PC.

module tb_cpu_core_sc64;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] prog [$];

  localparam logic signed [63:0] VA = -64'sd1000;
  localparam logic signed [63:0] VB = 64'sd200;
  localparam logic signed [63:0] VC = 64'sd300;
  localparam logic signed [63:0] VD = -64'sd400;
  localparam logic signed [63:0] VE = 64'sd40;
  localparam logic signed [63:0] VF = 64'sd3;
  localparam logic signed [63:0] VY = -64'sd18700;

  cpu_core_sc64 #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic emit(input logic [31:0] w);
    prog.push_back(w);
  endtask

  // Assert reset at a falling edge, clear memories, and empty the program buffer
  task automatic hold_reset_and_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dut.u_imem.rom[i] = 32'd0;
      dut.u_dmem.ram[i] = 64'd0;
    end
    prog.delete();
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) dut.u_imem.rom[i] = prog[i];
  endtask

  task automatic release_and_run(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic load_expression();
    dut.u_dmem.ram[0] = VA;
    dut.u_dmem.ram[1] = VB;
    dut.u_dmem.ram[2] = VC;
    dut.u_dmem.ram[3] = VD;
    dut.u_dmem.ram[4] = VE;
    dut.u_dmem.ram[5] = VF;
    dut.u_dmem.ram[6] = 64'd0;
    emit(32'h8C080000); emit(32'h8C090008); emit(32'h8C0A0010); emit(32'h8C0B0018);
    emit(32'h8C0C0020); emit(32'h8C0D0028); emit(32'h012A7022); emit(32'h01687820);
    emit(32'h01EC7818); emit(32'h01CF7020); emit(32'h01CD781A); emit(32'hAC0F0030);
    emit(32'h1000FFFF);
    load_prog();
  endtask

  task automatic check_inputs_intact(input string tag);
    logic signed [63:0] exp_v [6];
    exp_v = '{VA, VB, VC, VD, VE, VF};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dut.u_dmem.ram[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL %s ram[%0d]: got %0d expected %0d", tag, i,
                 $signed(dut.u_dmem.ram[i]), exp_v[i]);
      end
    end
  endtask

  task automatic check_regs_zero(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.regs[i] !== 64'd0) nz++;
    checks++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL %s: %0d nonzero registers, expected 0", tag, nz);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (dut.pc !== 64'd0) begin
      errors++;
      $display("FAIL reset_pc: got %0h expected 0", dut.pc);
    end
    check_regs_zero("reset_regs");
  endtask

  task automatic test_expression();
    hold_reset_and_clear();
    load_expression();
    release_and_run(14);
    checks++;
    if ($signed(dut.u_dmem.ram[6]) !== VY) begin
      errors++;
      $display("FAIL expr_y: got %0d expected %0d", $signed(dut.u_dmem.ram[6]), VY);
    end
    check_inputs_intact("expr_inputs");
    checks++;
    if (dut.pc !== 64'd48) begin
      errors++;
      $display("FAIL expr_pc: got %0d expected 48", dut.pc);
    end
  endtask

  task automatic test_halt();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (dut.pc !== 64'd48) begin
        errors++;
        $display("FAIL halt_pc cycle %0d: got %0d expected 48", c, dut.pc);
      end
    end
    checks++;
    if ($signed(dut.u_dmem.ram[6]) !== VY) begin
      errors++;
      $display("FAIL halt_y: got %0d expected %0d", $signed(dut.u_dmem.ram[6]), VY);
    end
  endtask

  task automatic test_reg_zero();
    hold_reset_and_clear();
    dut.u_dmem.ram[0] = 64'd5;
    emit(enc_i(6'h23, 5'd0, 5'd8, 16'd0));
    emit(enc_r(5'd8, 5'd8, 5'd0, 6'h20));
    emit(enc_i(6'h2B, 5'd0, 5'd0, 16'd0));
    emit(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    load_prog();
    release_and_run(6);
    checks++;
    if (dut.u_dmem.ram[0] !== 64'd0) begin
      errors++;
      $display("FAIL reg_zero: got %0d expected 0", dut.u_dmem.ram[0]);
    end
  endtask

  task automatic test_div_edges();
    logic signed [63:0] exp_v [4];
    exp_v = '{-64'sd3, -64'sd3, 64'sd0, {1'b1, 63'd0}};
    hold_reset_and_clear();
    dut.u_dmem.ram[0] = -64'sd7;
    dut.u_dmem.ram[1] = 64'sd2;
    dut.u_dmem.ram[2] = 64'sd7;
    dut.u_dmem.ram[3] = -64'sd2;
    dut.u_dmem.ram[4] = 64'sd0;
    dut.u_dmem.ram[5] = {1'b1, 63'd0};
    dut.u_dmem.ram[6] = -64'sd1;
    for (int i = 0; i < 4; i++) dut.u_dmem.ram[8+i] = 64'hDEAD;
    emit(enc_i(6'h23, 5'd0, 5'd8,  16'd0));
    emit(enc_i(6'h23, 5'd0, 5'd9,  16'd8));
    emit(enc_i(6'h23, 5'd0, 5'd10, 16'd16));
    emit(enc_i(6'h23, 5'd0, 5'd11, 16'd24));
    emit(enc_i(6'h23, 5'd0, 5'd12, 16'd32));
    emit(enc_i(6'h23, 5'd0, 5'd13, 16'd40));
    emit(enc_i(6'h23, 5'd0, 5'd14, 16'd48));
    emit(enc_r(5'd8, 5'd9, 5'd15, 6'h1A));
    emit(enc_i(6'h2B, 5'd0, 5'd15, 16'd64));
    emit(enc_r(5'd10, 5'd11, 5'd15, 6'h1A));
    emit(enc_i(6'h2B, 5'd0, 5'd15, 16'd72));
    emit(enc_r(5'd10, 5'd12, 5'd15, 6'h1A));
    emit(enc_i(6'h2B, 5'd0, 5'd15, 16'd80));
    emit(enc_r(5'd13, 5'd14, 5'd15, 6'h1A));
    emit(enc_i(6'h2B, 5'd0, 5'd15, 16'd88));
    emit(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    load_prog();
    release_and_run(20);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ($signed(dut.u_dmem.ram[8+i]) !== exp_v[i]) begin
        errors++;
        $display("FAIL div_case%0d: got %0d expected %0d", i,
                 $signed(dut.u_dmem.ram[8+i]), exp_v[i]);
      end
    end
  endtask

  task automatic test_alu_misc();
    logic signed [63:0] exp_v [7];
    exp_v = '{64'sh000F_000F_00F0_00F0, 64'sh0FFF_0FFF_F0FF_F0FF, 64'sd1, 64'sd0,
              -64'sd15, 64'sd0, 64'sd0};
    hold_reset_and_clear();
    dut.u_dmem.ram[0] = 64'h0F0F_0F0F_F0F0_F0F0;
    dut.u_dmem.ram[1] = 64'h00FF_00FF_00FF_00FF;
    dut.u_dmem.ram[2] = -64'sd5;
    dut.u_dmem.ram[3] = 64'sd3;
    for (int i = 0; i < 7; i++) dut.u_dmem.ram[8+i] = 64'hDEAD;
    emit(enc_i(6'h23, 5'd0, 5'd8,  16'd0));
    emit(enc_i(6'h23, 5'd0, 5'd9,  16'd8));
    emit(enc_i(6'h23, 5'd0, 5'd10, 16'd16));
    emit(enc_i(6'h23, 5'd0, 5'd11, 16'd24));
    emit(enc_r(5'd8, 5'd9, 5'd12, 6'h24));
    emit(enc_i(6'h2B, 5'd0, 5'd12, 16'd64));
    emit(enc_r(5'd8, 5'd9, 5'd12, 6'h25));
    emit(enc_i(6'h2B, 5'd0, 5'd12, 16'd72));
    emit(enc_r(5'd10, 5'd11, 5'd12, 6'h2A));
    emit(enc_i(6'h2B, 5'd0, 5'd12, 16'd80));
    emit(enc_r(5'd11, 5'd10, 5'd12, 6'h2A));
    emit(enc_i(6'h2B, 5'd0, 5'd12, 16'd88));
    emit(enc_r(5'd10, 5'd11, 5'd12, 6'h18));
    emit(enc_i(6'h2B, 5'd0, 5'd12, 16'd96));
    emit(enc_r(5'd8, 5'd9, 5'd20, 6'h26));
    emit(enc_i(6'h2B, 5'd0, 5'd20, 16'd104));
    emit(enc_i(6'h08, 5'd0, 5'd20, 16'd5));
    emit(enc_i(6'h2B, 5'd0, 5'd20, 16'd112));
    emit(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    load_prog();
    release_and_run(25);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ($signed(dut.u_dmem.ram[8+i]) !== exp_v[i]) begin
        errors++;
        $display("FAIL alu_case%0d: got %0h expected %0h", i, dut.u_dmem.ram[8+i], exp_v[i]);
      end
    end
  endtask

  task automatic run_branch(input logic [63:0] t1_val, input logic [63:0] exp_pc4,
                            input logic [63:0] exp_mark, input string tag);
    hold_reset_and_clear();
    dut.u_dmem.ram[0] = 64'd1;
    dut.u_dmem.ram[1] = t1_val;
    dut.u_dmem.ram[2] = 64'h55;
    emit(enc_i(6'h23, 5'd0, 5'd8,  16'd0));
    emit(enc_i(6'h23, 5'd0, 5'd9,  16'd8));
    emit(enc_i(6'h23, 5'd0, 5'd10, 16'd16));
    emit(enc_i(6'h04, 5'd8, 5'd9,  16'd2));
    emit(enc_i(6'h2B, 5'd0, 5'd10, 16'd64));
    emit(32'd0);
    emit(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    load_prog();
    release_and_run(4);
    checks++;
    if (dut.pc !== exp_pc4) begin
      errors++;
      $display("FAIL %s_pc: got %0d expected %0d", tag, dut.pc, exp_pc4);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (dut.u_dmem.ram[8] !== exp_mark) begin
      errors++;
      $display("FAIL %s_marker: got %0h expected %0h", tag, dut.u_dmem.ram[8], exp_mark);
    end
    checks++;
    if (dut.pc !== 64'd24) begin
      errors++;
      $display("FAIL %s_halt_pc: got %0d expected 24", tag, dut.pc);
    end
  endtask

  task automatic test_branch();
    run_branch(64'd2, 64'd16, 64'h55, "beq_not_taken");
    run_branch(64'd1, 64'd24, 64'h0,  "beq_taken");
  endtask

  task automatic test_async_reset();
    hold_reset_and_clear();
    load_expression();
    release_and_run(7);
    checks++;
    if (dut.pc !== 64'd28) begin
      errors++;
      $display("FAIL areset_pre_pc: got %0d expected 28", dut.pc);
    end
    checks++;
    if ($signed(dut.regs[8]) !== VA) begin
      errors++;
      $display("FAIL areset_pre_t0: got %0d expected %0d", $signed(dut.regs[8]), VA);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dut.pc !== 64'd0) begin
      errors++;
      $display("FAIL areset_pc: got %0d expected 0", dut.pc);
    end
    check_regs_zero("areset_regs");
    @(negedge clk);
    checks++;
    if (dut.pc !== 64'd0) begin
      errors++;
      $display("FAIL areset_hold_pc: got %0d expected 0", dut.pc);
    end
    check_inputs_intact("areset_ram");
    checks++;
    if (dut.u_dmem.ram[6] !== 64'd0) begin
      errors++;
      $display("FAIL areset_y_untouched: got %0d expected 0", $signed(dut.u_dmem.ram[6]));
    end
    reset = 1'b1;
    repeat (14) @(negedge clk);
    checks++;
    if ($signed(dut.u_dmem.ram[6]) !== VY) begin
      errors++;
      $display("FAIL areset_rerun_y: got %0d expected %0d", $signed(dut.u_dmem.ram[6]), VY);
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_expression();
    test_halt();
    test_reg_zero();
    test_div_edges();
    test_alu_misc();
    test_branch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
